// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader.
// The DM-clear stage is built only when PROG_LOADER_DM_CLEAR_EN is defined.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    ZFILL,
    CLEAR,
    DONE,
    ERR
  } state_t;

  localparam int         DEF_IM_DEPTH  = 32;
  localparam int         DEF_DM_BYTES  = 128;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  // Address width for a memory of the given depth (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that must be able to hold the value 'depth' itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prog_loader_asm.sv
// Byte-to-word assembler: shifts bytes MSB first into a 32-bit word and
// keeps a running XOR checksum of every byte it takes.
module prog_loader_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [7:0]  csum,
  output logic        lane_last
);

  logic [1:0] lane;

  // High while the byte being offered completes the current word.
  assign lane_last = (lane == 2'd3);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
      csum       <= 8'd0;
    end else begin
      word_valid <= byte_valid && lane_last;
      if (clear) begin
        lane <= 2'd0;
        csum <= 8'd0;
      end else if (byte_valid) begin
        lane <= lane + 2'd1;
        word <= {word[23:0], byte_in};
        csum <= csum ^ byte_in;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses a framed byte stream into IM words, zero-fills the
// rest of IM and (with PROG_LOADER_DM_CLEAR_EN) clears DM before releasing the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         IM_DEPTH  = DEF_IM_DEPTH,
  parameter int         DM_BYTES  = DEF_DM_BYTES,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic                          im_we_o,
  output logic [addr_w(IM_DEPTH)-1:0]   im_addr_o,
  output logic [31:0]                   im_wdata_o,
  output logic                          dm_we_o,
  output logic [addr_w(DM_BYTES)-1:0]   dm_addr_o,
  output logic [7:0]                    dm_wdata_o,
  output logic                          cpu_rst_n_o,
  output logic                          busy_o,
  output logic                          err_o,
  output logic                          done_o
);

  localparam int            AW       = addr_w(IM_DEPTH);
  localparam int            CW       = cnt_w(IM_DEPTH);
  localparam logic [CW-1:0] IDX_LAST = CW'(IM_DEPTH - 1);
  localparam logic [CW-1:0] IDX_FULL = CW'(IM_DEPTH);
  localparam logic [8:0]    N_MAX    = 9'(IM_DEPTH);

  state_t        state, state_nxt;
  logic [CW-1:0] n_words, word_idx;
  logic          take, byte_valid, asm_clear;
  logic          lane_last, word_valid, dm_last;
  logic [31:0]   word;
  logic [7:0]    csum;

  assign take       = s_valid_i && s_ready_o;
  assign byte_valid = take && (state == DATA);

  prog_loader_asm u_asm (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .byte_valid (byte_valid),
    .clear      (asm_clear),
    .byte_in    (s_data_i),
    .word       (word),
    .word_valid (word_valid),
    .csum       (csum),
    .lane_last  (lane_last)
  );

`ifdef PROG_LOADER_DM_CLEAR_EN
  localparam int            DW         = addr_w(DM_BYTES);
  localparam logic [DW-1:0] DM_LAST    = DW'(DM_BYTES - 1);
  localparam state_t        ZFILL_EXIT = CLEAR;

  logic [DW-1:0] dm_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dm_cnt <= '0;
    end else if (state == COUNT) begin
      dm_cnt <= '0;
    end else if (state == CLEAR && !dm_last) begin
      dm_cnt <= dm_cnt + 1'b1;
    end
  end

  assign dm_last   = (dm_cnt == DM_LAST);
  assign dm_we_o   = (state == CLEAR);
  assign dm_addr_o = dm_cnt;
`else
  localparam state_t ZFILL_EXIT = DONE;

  assign dm_last   = 1'b1;
  assign dm_we_o   = 1'b0;
  assign dm_addr_o = '0;
`endif

  assign dm_wdata_o = 8'd0;

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    state_nxt = state;
    asm_clear = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (take && s_data_i == SYNC_BYTE) state_nxt = COUNT;
      end
      COUNT: begin
        if (take) begin
          if (s_data_i == 8'd0 || {1'b0, s_data_i} > N_MAX) begin
            state_nxt = ERR;
          end else begin
            state_nxt = DATA;
            asm_clear = 1'b1;
          end
        end
      end
      // The word index still equals the word being assembled on its 4th byte,
      // since the previous word's write finished at least three cycles earlier.
      DATA: begin
        if (byte_valid && lane_last && word_idx == n_words - 1'b1) state_nxt = CHECK;
      end
      CHECK: begin
        if (take) begin
          if (s_data_i != csum)         state_nxt = ERR;
          else if (n_words == IDX_FULL) state_nxt = ZFILL_EXIT;
          else                          state_nxt = ZFILL;
        end
      end
      ZFILL: begin
        if (word_idx == IDX_LAST) state_nxt = ZFILL_EXIT;
      end
      CLEAR: begin
        if (dm_last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      n_words  <= '0;
      word_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == COUNT && take) begin
        n_words  <= s_data_i[CW-1:0];
        word_idx <= '0;
      end else if (im_we_o && word_idx != IDX_FULL) begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

  assign s_ready_o   = !(state == ZFILL || state == CLEAR);
  assign im_we_o     = word_valid || (state == ZFILL);
  assign im_addr_o   = word_idx[AW-1:0];
  assign im_wdata_o  = word_valid ? word : 32'd0;
  assign busy_o      = state inside {COUNT, DATA, CHECK, ZFILL, CLEAR};
  assign cpu_rst_n_o = (state == DONE);
  assign done_o      = (state == DONE);
  assign err_o       = (state == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a frame-level model predicts every
// memory write and the final status; a compare process checks each strobe.
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int         IM_DEPTH = 32;
  localparam int         DM_BYTES = 128;
  localparam logic [7:0] SYNC     = 8'hA5;
`ifdef PROG_LOADER_DM_CLEAR_EN
  localparam int DM_WRITES = DM_BYTES;
`else
  localparam int DM_WRITES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  s_data_i = 8'd0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o, im_we_o, dm_we_o, cpu_rst_n_o, busy_o, err_o, done_o;
  logic [4:0]  im_addr_o;
  logic [31:0] im_wdata_o;
  logic [6:0]  dm_addr_o;
  logic [7:0]  dm_wdata_o;

  prog_loader #(
    .IM_DEPTH  (IM_DEPTH),
    .DM_BYTES  (DM_BYTES),
    .SYNC_BYTE (SYNC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .im_we_o     (im_we_o),
    .im_addr_o   (im_addr_o),
    .im_wdata_o  (im_wdata_o),
    .dm_we_o     (dm_we_o),
    .dm_addr_o   (dm_addr_o),
    .dm_wdata_o  (dm_wdata_o),
    .cpu_rst_n_o (cpu_rst_n_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dm;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        zf;
  } wr_t;

  typedef enum {O_NONE, O_DONE, O_ERR} outcome_t;

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  wr_t        cur;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: walks the byte list and lists every write it implies.
  task automatic model_frame(output outcome_t oc);
    int         i, n;
    logic [7:0] x;
    wr_t        e;
    i  = 0;
    oc = O_NONE;
    while (i < frame_q.size()) begin
      if (frame_q[i] != SYNC) begin
        i++;
        continue;
      end
      oc = O_NONE;
      i++;
      if (i >= frame_q.size()) return;
      n = int'(frame_q[i]);
      i++;
      if (n == 0 || n > IM_DEPTH) begin
        oc = O_ERR;
        continue;
      end
      x = 8'd0;
      for (int k = 0; k < n; k++) begin
        if (i + 4 > frame_q.size()) return;
        e.dm   = 1'b0;
        e.addr = 8'(k);
        e.data = {frame_q[i], frame_q[i+1], frame_q[i+2], frame_q[i+3]};
        e.zf   = 1'b0;
        exp_q.push_back(e);
        x = x ^ frame_q[i] ^ frame_q[i+1] ^ frame_q[i+2] ^ frame_q[i+3];
        i += 4;
      end
      if (i >= frame_q.size()) return;
      if (frame_q[i] != x) begin
        oc = O_ERR;
      end else begin
        for (int a = n; a < IM_DEPTH; a++) begin
          e.dm = 1'b0; e.addr = 8'(a); e.data = 32'd0; e.zf = 1'b1;
          exp_q.push_back(e);
        end
        for (int d = 0; d < DM_WRITES; d++) begin
          e.dm = 1'b1; e.addr = 8'(d); e.data = 32'd0; e.zf = 1'b1;
          exp_q.push_back(e);
        end
        oc = O_DONE;
      end
      i++;
    end
  endtask

  // Every strobe is matched against the next predicted write.
  always @(negedge clk) begin
    if (!rst_i) begin
      check("reset_quiet", 64'({im_we_o, dm_we_o}), 64'd0);
    end else if (im_we_o || dm_we_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'({im_we_o, dm_we_o, im_addr_o, dm_addr_o}), 64'd0);
      end else begin
        cur = exp_q.pop_front();
        check("write_kind", 64'({im_we_o, dm_we_o}), 64'({!cur.dm, cur.dm}));
        if (cur.dm) begin
          check("dm_addr", 64'(dm_addr_o), 64'(cur.addr));
          check("dm_wdata", 64'(dm_wdata_o), 64'd0);
        end else begin
          check("im_addr", 64'(im_addr_o), 64'(cur.addr));
          check("im_wdata", 64'(im_wdata_o), 64'(cur.data));
        end
        check("ready_during_write", 64'(s_ready_o), 64'(!cur.zf));
        check("cpu_held_during_write", 64'(cpu_rst_n_o), 64'd0);
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string nm);
    check(nm, 64'({cpu_rst_n_o, im_we_o, dm_we_o, busy_o, err_o, done_o, s_ready_o}),
          64'(7'b0000001));
    check({nm, "_addr_data"}, 64'({im_addr_o, dm_addr_o, im_wdata_o}), 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        s_valid_i = 1'b0;
        s_data_i  = 8'($urandom);
        align();
      end
    end
    s_valid_i = 1'b1;
    s_data_i  = b;
    budget    = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!s_ready_o && budget < 1000);
    if (!s_ready_o) check("ready_timeout", 64'(s_ready_o), 64'd1);
    align();
    s_valid_i = 1'b0;
  endtask

  task automatic run_frame(input bit gaps, input bit reload_chk);
    outcome_t oc;
    int       budget;
    model_frame(oc);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], gaps);
      if (reload_chk && i == 0)
        check("reload_cpu_drop", 64'({cpu_rst_n_o, done_o, busy_o}), 64'(3'b001));
    end
    budget = 0;
    while (!(done_o || err_o) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("outcome_done", 64'(done_o), 64'(oc == O_DONE));
    check("outcome_err", 64'(err_o), 64'(oc == O_ERR));
    check("outcome_cpu", 64'({cpu_rst_n_o, busy_o, s_ready_o}), 64'({oc == O_DONE, 1'b0, 1'b1}));
    check("writes_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    frame_q.delete();
    align();
  endtask

  task automatic set_good(input logic [7:0] last);
    frame_q = '{8'hA5, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                8'h20, 8'h02, 8'h00, 8'h03, last};
  endtask

  task automatic build_random(input int n, input bit corrupt, input int junk);
    logic [7:0] b, x;
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      frame_q.push_back(b);
    end
    frame_q.push_back(SYNC);
    frame_q.push_back(8'(n));
    x = 8'd0;
    for (int j = 0; j < 4 * n; j++) begin
      b = 8'($urandom);
      x = x ^ b;
      frame_q.push_back(b);
    end
    if (corrupt) x = x ^ 8'($urandom_range(1, 255));
    frame_q.push_back(x);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    outcome_t oc;

    #22;
    check_reset_vals("reset_vals");
    rst_i = 1'b1;
    align();

    // Pin the model against hand-computed values for the reference frame.
    set_good(8'h05);
    model_frame(oc);
    check("pin_good_outcome", 64'(oc == O_DONE), 64'd1);
    check("pin_word0", 64'(exp_q[0].data), 64'h20010005);
    check("pin_word1", 64'(exp_q[1].data), 64'h20020003);
    check("pin_zfill_first", 64'({exp_q[2].addr, exp_q[2].zf}), 64'({8'd2, 1'b1}));
    check("pin_total_writes", 64'(exp_q.size()), 64'(IM_DEPTH + DM_WRITES));
    exp_q.delete();
    set_good(8'h06);
    model_frame(oc);
    check("pin_bad_outcome", 64'(oc == O_ERR), 64'd1);
    check("pin_bad_writes", 64'(exp_q.size()), 64'd2);
    exp_q.delete();

    // Good load, valid held high.
    set_good(8'h05);
    run_frame(1'b0, 1'b0);

    // Bad checksum, then recovery.
    set_good(8'h06);
    run_frame(1'b0, 1'b0);
    set_good(8'h05);
    run_frame(1'b0, 1'b0);

    // Count bounds, including a full-depth frame with no zero-fill.
    frame_q = '{8'hA5, 8'h00};
    run_frame(1'b0, 1'b0);
    frame_q = '{8'hA5, 8'h21};
    run_frame(1'b0, 1'b0);
    build_random(IM_DEPTH, 1'b0, 0);
    run_frame(1'b0, 1'b0);

    // Gaps plus junk before the sync byte.
    set_good(8'h05);
    frame_q.push_front(8'hFF);
    frame_q.push_front(8'h00);
    run_frame(1'b1, 1'b0);

    // Sync byte values inside the payload are plain data.
    frame_q = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    run_frame(1'b1, 1'b0);

    // Reset after the 5th data byte.
    frame_q = '{8'hA5, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h20};
    model_frame(oc);
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b0);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_vals("mid_reset_vals");
    repeat (3) @(negedge clk);
    check("mid_reset_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    frame_q.delete();
    #2;
    rst_i = 1'b1;
    align();
    set_good(8'h05);
    run_frame(1'b0, 1'b0);

    // Reload straight out of DONE.
    check("pre_reload_done", 64'(done_o), 64'd1);
    build_random(3, 1'b0, 0);
    run_frame(1'b0, 1'b1);

    // Randomized frames with junk, gaps and occasional bad checksums.
    for (int r = 0; r < 8; r++) begin
      build_random($urandom_range(1, IM_DEPTH), ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 2));
      run_frame(1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
